// File: rtl/dijkstra_engine.sv
// -----------------------------------------------------------------------------
// dijkstra_engine
//
// Shortest-path sequencer that sits downstream of the node adjacency table.
// It runs Dijkstra from src to dst by repeating three steps:
//   - a linear SCAN for the cheapest unvisited node,
//   - a FETCH of that node's table row,
//   - a RELAX of the four returned neighbour slots.
// It then streams the path (dst first, src last) over a valid/ready interface.
// At the end it pulses done together with found and cost.
//
// Parameters
//   NODES  number of graph nodes, valid ids 0..NODES-1
//   AW     node id width
//   DW     distance width; all-ones is INF
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, src, dst   one-cycle request, sampled only while idle
//   nd_add            node address to the adjacency table (0 when not fetching)
//   nb0..nb3          neighbour entries, bits [0:1] weight, [2:6] id;
//                     an id >= NODES is an empty slot
//   busy              high from the cycle after an accepted start until done
//   path_valid/ready  path stream handshake
//   path_node         current path node, emitted dst to src
//   path_last         marks the src node
//   done              one-cycle end-of-search pulse
//   found, cost       search result, updated with done and held afterwards
//
// Configuration
//   UNIT_WEIGHT_EN    when defined, every valid slot has weight 1, so cost is
//                     the hop count; otherwise the 2-bit entry weight is used.
// -----------------------------------------------------------------------------
module dijkstra_engine #(
    parameter int NODES = 26,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    output logic [AW-1:0] nd_add,
    input  logic [0:6]    nb0,
    input  logic [0:6]    nb1,
    input  logic [0:6]    nb2,
    input  logic [0:6]    nb3,
    output logic          busy,
    output logic          path_valid,
    output logic [AW-1:0] path_node,
    output logic          path_last,
    input  logic          path_ready,
    output logic          done,
    output logic          found,
    output logic [DW-1:0] cost
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_RELAX = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [DW-1:0] INF     = {DW{1'b1}};
    // Relaxed distances saturate one below INF so a reached node never
    // looks unreachable.
    localparam logic [DW-1:0] SAT     = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [AW-1:0] LAST_ID = AW'(NODES - 1);

    // ------------------------------------------------------------------
    // Neighbour slot unpacking
    // ------------------------------------------------------------------
    logic [1:0] slot_w  [4];
    logic [4:0] slot_id [4];

    assign slot_id[0] = nb0[2:6];
    assign slot_id[1] = nb1[2:6];
    assign slot_id[2] = nb2[2:6];
    assign slot_id[3] = nb3[2:6];

`ifdef UNIT_WEIGHT_EN
    // Hop-count mode: the table weights are deliberately ignored.
    logic unused_w;
    assign unused_w   = ^{nb0[0:1], nb1[0:1], nb2[0:1], nb3[0:1]};
    assign slot_w[0]  = 2'd1;
    assign slot_w[1]  = 2'd1;
    assign slot_w[2]  = 2'd1;
    assign slot_w[3]  = 2'd1;
`else
    assign slot_w[0]  = nb0[0:1];
    assign slot_w[1]  = nb1[0:1];
    assign slot_w[2]  = nb2[0:1];
    assign slot_w[3]  = nb3[0:1];
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] src_q,       src_d;
    logic [AW-1:0] dst_q,       dst_d;
    logic [AW-1:0] u_q,         u_d;          // node being expanded
    logic [AW-1:0] idx_q,       idx_d;        // scan index
    logic [AW-1:0] best_q,      best_d;       // best candidate so far
    logic [DW-1:0] bestd_q,     bestd_d;      // its distance
    logic [AW-1:0] path_node_q, path_node_d;
    logic          hit_q,       hit_d;        // path walked to src
    logic          done_q,      done_d;
    logic          found_q,     found_d;
    logic [DW-1:0] cost_q,      cost_d;

    logic [DW-1:0] dist_q [NODES];
    logic [DW-1:0] dist_d [NODES];
    logic [AW-1:0] pred_q [NODES];
    logic [AW-1:0] pred_d [NODES];
    logic [NODES-1:0] visited_q, visited_d;

    // Scan / relax helpers
    logic          take;
    logic [AW-1:0] best_n;
    logic [DW-1:0] bestd_n;
    logic [DW:0]   alt_sum;
    logic [DW-1:0] alt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        u_d         = u_q;
        idx_d       = idx_q;
        best_d      = best_q;
        bestd_d     = bestd_q;
        path_node_d = path_node_q;
        hit_d       = hit_q;
        done_d      = 1'b0;
        found_d     = found_q;
        cost_d      = cost_q;
        dist_d      = dist_q;
        pred_d      = pred_q;
        visited_d   = visited_q;
        take        = 1'b0;
        best_n      = best_q;
        bestd_n     = bestd_q;
        alt_sum     = '0;
        alt         = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hit_d = 1'b0;
                    if (src > LAST_ID || dst > LAST_ID) begin
                        state_d = S_FIN;
                    end else begin
                        src_d   = src;
                        dst_d   = dst;
                        state_d = S_INIT;
                    end
                end
            end

            S_INIT: begin
                for (int n = 0; n < NODES; n++) begin
                    dist_d[n] = (src_q == AW'(n)) ? '0 : INF;
                    pred_d[n] = '0;
                end
                visited_d = '0;
                idx_d     = '0;
                best_d    = '0;
                bestd_d   = INF;
                state_d   = S_SCAN;
            end

            S_SCAN: begin
                // Strict compare while walking upwards keeps the lowest index
                // on a tie; bestd starts at INF so unreachable nodes never win.
                take    = !visited_q[idx_q] && (dist_q[idx_q] < bestd_q);
                best_n  = take ? idx_q : best_q;
                bestd_n = take ? dist_q[idx_q] : bestd_q;
                best_d  = best_n;
                bestd_d = bestd_n;
                idx_d   = idx_q + AW'(1);
                if (idx_q == LAST_ID) begin
                    if (bestd_n == INF) begin
                        state_d = S_FIN;
                    end else if (best_n == dst_q) begin
                        path_node_d = dst_q;
                        state_d     = S_EMIT;
                    end else begin
                        visited_d[best_n] = 1'b1;
                        u_d               = best_n;
                        state_d           = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_RELAX;
            end

            S_RELAX: begin
                // NOTE: blocking updates to dist_d inside this combinational
                // loop are intentional: a later slot must see the distance an
                // earlier slot just wrote when both name the same neighbour.
                for (int s = 0; s < 4; s++) begin
                    alt_sum = {1'b0, dist_q[u_q]} + (DW+1)'(slot_w[s]);
                    alt     = (alt_sum > {1'b0, SAT}) ? SAT : alt_sum[DW-1:0];
                    for (int n = 0; n < NODES; n++) begin
                        if (slot_id[s] == 5'(n) && !visited_q[n] && alt < dist_d[n]) begin
                            dist_d[n] = alt;
                            pred_d[n] = u_q;
                        end
                    end
                end
                idx_d   = '0;
                best_d  = '0;
                bestd_d = INF;
                state_d = S_SCAN;
            end

            S_EMIT: begin
                if (path_ready) begin
                    if (path_node_q == src_q) begin
                        hit_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        path_node_d = pred_q[path_node_q];
                    end
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                found_d = hit_q;
                cost_d  = hit_q ? dist_q[dst_q] : INF;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: the distance/predecessor tables are flops, not RAM, and are
    // cleared by reset so every output and all search state start known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            u_q         <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            bestd_q     <= '0;
            path_node_q <= '0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            cost_q      <= '0;
            visited_q   <= '0;
            for (int n = 0; n < NODES; n++) begin
                dist_q[n] <= '0;
                pred_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            u_q         <= u_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            bestd_q     <= bestd_d;
            path_node_q <= path_node_d;
            hit_q       <= hit_d;
            done_q      <= done_d;
            found_q     <= found_d;
            cost_q      <= cost_d;
            visited_q   <= visited_d;
            dist_q      <= dist_d;
            pred_q      <= pred_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // done is registered out of FIN, so it lands in the first idle cycle and
    // busy (any non-idle state) drops in that same cycle.
    assign busy       = (state_q != S_IDLE);
    assign nd_add     = (state_q == S_FETCH || state_q == S_RELAX) ? u_q : '0;
    assign path_valid = (state_q == S_EMIT);
    assign path_node  = path_node_q;
    assign path_last  = path_valid && (path_node_q == src_q);
    assign done       = done_q;
    assign found      = found_q;
    assign cost       = cost_q;

endmodule

// File: tb/tb_dijkstra_engine.sv
// -----------------------------------------------------------------------------
// tb_dijkstra_engine
//
// Directed bench for dijkstra_engine. A small fixed adjacency table answers
// nd_add combinationally. Each search checks the streamed path, the
// path_last flag, found/cost and the busy/done timing against hand-computed
// values.
//
// Graph (weight,id):
//   0: (3,1) (1,8)   1: (2,2) (3,0)   2: (2,3) (1,9)   3: (1,2)
//   4: (3,6) (1,6) (3,10)   6: (3,5) (2,4)   8: (3,9)   9: (3,1)   10: (1,5)
// -----------------------------------------------------------------------------
module tb_dijkstra_engine;

    localparam int NODES = 26;
    localparam int AW    = 5;
    localparam int DW    = 8;

`ifdef UNIT_WEIGHT_EN
    localparam int COST_0_3 = 3;
    localparam int COST_4_5 = 2;
`else
    localparam int COST_0_3 = 7;
    localparam int COST_4_5 = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW-1:0] nd_add;
    logic [0:6]    nb0, nb1, nb2, nb3;
    logic          busy;
    logic          path_valid;
    logic [AW-1:0] path_node;
    logic          path_last;
    logic          path_ready = 1'b1;
    logic          done;
    logic          found;
    logic [DW-1:0] cost;

    int passed = 0;
    int total  = 0;

    int exp_q  [$];
    int got_q  [$];
    int last_q [$];

    dijkstra_engine #(.NODES(NODES), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .nd_add     (nd_add),
        .nb0        (nb0),
        .nb1        (nb1),
        .nb2        (nb2),
        .nb3        (nb3),
        .busy       (busy),
        .path_valid (path_valid),
        .path_node  (path_node),
        .path_last  (path_last),
        .path_ready (path_ready),
        .done       (done),
        .found      (found),
        .cost       (cost)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Adjacency table model
    // ------------------------------------------------------------------
    function automatic logic [6:0] ent(input int w, input int id);
        logic [1:0] wv;
        logic [4:0] iv;
        wv = 2'(w);
        iv = 5'(id);
        return {wv, iv};
    endfunction

    function automatic logic [27:0] table_row(input logic [4:0] a);
        logic [6:0] ea;
        logic [6:0] eb;
        ea = ent(3, 31);   // empty, id well above range
        eb = ent(0, 26);   // empty, first id past the last node
        case (a)
            5'd0:    return {ent(3, 1), ent(1, 8), eb, ea};
            5'd1:    return {ent(2, 2), ent(3, 0), ea, ea};
            5'd2:    return {eb, ent(2, 3), ent(1, 9), ea};
            5'd3:    return {ent(1, 2), ea, ea, ea};
            5'd4:    return {ent(3, 6), ent(1, 6), ent(3, 10), ea};
            5'd6:    return {ent(3, 5), ent(2, 4), ea, eb};
            5'd8:    return {ent(3, 9), ea, ea, ea};
            5'd9:    return {ent(3, 1), ea, ea, ea};
            5'd10:   return {ent(1, 5), ea, ea, ea};
            default: return {ea, ea, ea, ea};
        endcase
    endfunction

    always_comb {nb0, nb1, nb2, nb3} = table_row(nd_add);

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_nd_add"},     32'(nd_add),     0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_path_valid"}, 32'(path_valid), 0);
        check({tag, "_path_node"},  32'(path_node),  0);
        check({tag, "_path_last"},  32'(path_last),  0);
        check({tag, "_done"},       32'(done),       0);
        check({tag, "_found"},      32'(found),      0);
        check({tag, "_cost"},       32'(cost),       0);
    endtask

    // Runs one search and compares the collected path with exp_q.
    // stall: hold path_ready low for 5 cycles after the first node.
    // poke:  pulse start with other operands while the search is busy.
    task automatic run_search(input string tag, input int s, input int d,
                              input int exp_found, input int exp_cost,
                              input bit stall, input bit poke);
        int  cyc;
        int  stall_cnt;
        int  held;
        bit  seen_done;
        @(negedge clk);
        start = 1'b1;
        src   = AW'(s);
        dst   = AW'(d);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 1);
        got_q.delete();
        last_q.delete();
        cyc       = 0;
        stall_cnt = 0;
        held      = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                src   = AW'(7);
                dst   = AW'(7);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
            end else if (path_valid) begin
                if (stall && got_q.size() == 1 && stall_cnt < 5) begin
                    path_ready = 1'b0;
                    if (stall_cnt == 0) held = int'(path_node);
                    else check({tag, "_stall_hold"}, 32'(path_node), 32'(held));
                    stall_cnt++;
                end else begin
                    path_ready = 1'b1;
                    got_q.push_back(int'(path_node));
                    last_q.push_back(int'(path_last));
                end
            end
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start      = 1'b0;
        path_ready = 1'b1;
        if (!seen_done) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_found"},        32'(found), 32'(exp_found));
            check({tag, "_cost"},         32'(cost),  32'(exp_cost));
            check({tag, "_busy_at_done"}, 32'(busy),  0);
            check({tag, "_path_len"},     32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got_q.size()) begin
                    check($sformatf("%s_node%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
                    check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]),
                          (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
                end
            end
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit           hit;
        logic [AW-1:0] prev;

        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_q = '{3, 2, 1, 0};
        run_search("s0_d3", 0, 3, 1, COST_0_3, 1'b0, 1'b0);

        exp_q = '{5, 6, 4};
        run_search("s4_d5", 4, 5, 1, COST_4_5, 1'b1, 1'b1);

        exp_q = '{7};
        run_search("s7_d7", 7, 7, 1, 0, 1'b0, 1'b0);

        // Reachable set from 0 is {0,1,2,3,8,9}: node 25 exhausts the scan.
        exp_q = {};
        run_search("s0_d25", 0, 25, 0, 255, 1'b0, 1'b0);

        // Out-of-range destination: straight to FIN, done two cycles later.
        @(negedge clk);
        start = 1'b1;
        src   = AW'(0);
        dst   = AW'(27);
        @(negedge clk);
        start = 1'b0;
        check("bad_dst_busy",        32'(busy),       1);
        check("bad_dst_early_done",  32'(done),       0);
        check("bad_dst_valid1",      32'(path_valid), 0);
        @(negedge clk);
        check("bad_dst_done",        32'(done),       1);
        check("bad_dst_found",       32'(found),      0);
        check("bad_dst_cost",        32'(cost),       255);
        check("bad_dst_busy_low",    32'(busy),       0);
        check("bad_dst_valid2",      32'(path_valid), 0);

        // Reset in the RELAX cycle of node 8 (nd_add stays 8 through FETCH
        // and RELAX, so the second consecutive sighting is RELAX).
        @(negedge clk);
        start = 1'b1;
        src   = AW'(0);
        dst   = AW'(3);
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        prev  = '0;
        for (int c = 0; c < 600; c++) begin
            if (nd_add == AW'(8) && prev == AW'(8)) begin
                hit = 1'b1;
                break;
            end
            prev = nd_add;
            @(negedge clk);
        end
        check("relax_reached", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_next_cycle");
        @(negedge clk);
        rst_n = 1'b1;

        exp_q = '{3, 2, 1, 0};
        run_search("after_rst", 0, 3, 1, COST_0_3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
